ball_motion_controller: RTL and testbench

Advances the pong ball one step per game tick and resolves wall, paddle and goal events. It sits directly upstream of the delay timer: it holds `delay` high to request a tick and consumes the timer's one-cycle `done` pulse. Registered `ballX`/`ballY` feed the VGA pixel renderer. Score pulses feed the score counters.

---
 rtl/ball_motion_controller.sv | 149 ++++++++++++++
 tb/tb_ball_motion_controller.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ball_motion_controller.sv
// Pong ball motion: steps the ball once per delay-timer tick and
// resolves wall bounces, paddle hits and goals.
`timescale 1ns/1ps
module ball_motion_controller #(
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE       = 480,
    parameter int BALL_SIZE      = 8,
    parameter int STEP           = 2,
    parameter int PADDLE_W       = 8,
    parameter int PADDLE_H       = 64,
    parameter int PADDLE_X_LEFT  = 16,
    parameter int PADDLE_X_RIGHT = 616
) (
    input  logic       CLK_100MHz,
    input  logic       Reset,
    input  logic       enable,
    input  logic       done,
    input  logic [9:0] paddleLeftY,
    input  logic [9:0] paddleRightY,
    output logic       delay,
    output logic [9:0] ballX,
    output logic [9:0] ballY,
    output logic       scoreLeft,
    output logic       scoreRight
);

    localparam logic [10:0] BS11    = 11'(BALL_SIZE);
    localparam logic [10:0] STEP11  = 11'(STEP);
    localparam logic [10:0] PH11    = 11'(PADDLE_H);
    localparam logic [10:0] Y_MAX11 = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] X_MAX11 = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] FACE_L  = 11'(PADDLE_X_LEFT + PADDLE_W);
    localparam logic [10:0] FACE_R  = 11'(PADDLE_X_RIGHT);

    localparam logic [9:0] X_CTR   = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] Y_CTR   = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] Y_MAX   = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0] X_HIT_L = 10'(PADDLE_X_LEFT + PADDLE_W);
    localparam logic [9:0] X_HIT_R = 10'(PADDLE_X_RIGHT - BALL_SIZE);

    typedef enum logic [1:0] {
        SIDLE,
        SWAIT,
        SUPDATE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic dir_right;
    logic dir_down;

    logic [10:0] x11, y11, nx, ny;
    logic [10:0] pl11, pr11;
    logic        ov_l, ov_r;
    logic [9:0]  x_nxt, y_nxt;
    logic        dx_nxt, dy_nxt;
    logic        score_l, score_r;

    always_ff @(posedge CLK_100MHz or negedge Reset) begin
        if (!Reset) state <= SIDLE;
        else        state <= state_nxt;
    end

    // Dropping enable wins over a coincident done
    always_comb begin
        state_nxt = state;
        case (state)
            SIDLE:   if (enable) state_nxt = SWAIT;
            SWAIT: begin
                if (!enable)   state_nxt = SIDLE;
                else if (done) state_nxt = SUPDATE;
            end
            SUPDATE: state_nxt = enable ? SWAIT : SIDLE;
            default: state_nxt = SIDLE;
        endcase
    end

    assign delay = (state == SWAIT);

    always_comb begin
        x11  = {1'b0, ballX};
        y11  = {1'b0, ballY};
        pl11 = {1'b0, paddleLeftY};
        pr11 = {1'b0, paddleRightY};
        nx   = dir_right ? x11 + STEP11 : x11 - STEP11;
        ny   = dir_down  ? y11 + STEP11 : y11 - STEP11;
        ov_l = (y11 + BS11 > pl11) && (y11 < pl11 + PH11);
        ov_r = (y11 + BS11 > pr11) && (y11 < pr11 + PH11);

        y_nxt = ny[9:0];
        dy_nxt = dir_down;
        if (dir_down && ny >= Y_MAX11) begin
            y_nxt  = Y_MAX;
            dy_nxt = 1'b0;
        end else if (!dir_down && y11 <= STEP11) begin
            y_nxt  = '0;
            dy_nxt = 1'b1;
        end

        x_nxt   = nx[9:0];
        dx_nxt  = dir_right;
        score_l = 1'b0;
        score_r = 1'b0;
        // Paddle test only on the tick that crosses the face
        if (dir_right) begin
            if (x11 + BS11 < FACE_R && nx + BS11 >= FACE_R && ov_r) begin
                x_nxt  = X_HIT_R;
                dx_nxt = 1'b0;
            end else if (nx >= X_MAX11) begin
                score_l = 1'b1;
            end
        end else begin
            if (x11 > FACE_L && nx <= FACE_L && ov_l) begin
                x_nxt  = X_HIT_L;
                dx_nxt = 1'b1;
            end else if (x11 <= STEP11) begin
                score_r = 1'b1;
            end
        end

        if (score_l || score_r) begin
            x_nxt = X_CTR;
            y_nxt = Y_CTR;
        end
    end

    always_ff @(posedge CLK_100MHz or negedge Reset) begin
        if (!Reset) begin
            ballX      <= X_CTR;
            ballY      <= Y_CTR;
            dir_right  <= 1'b1;
            dir_down   <= 1'b1;
            scoreLeft  <= 1'b0;
            scoreRight <= 1'b0;
        end else if (state == SUPDATE) begin
            ballX      <= x_nxt;
            ballY      <= y_nxt;
            dir_right  <= dx_nxt;
            dir_down   <= dy_nxt;
            scoreLeft  <= score_l;
            scoreRight <= score_r;
        end else begin
            scoreLeft  <= 1'b0;
            scoreRight <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ball_motion_controller.sv
// Directed bench for ball_motion_controller; done is driven by hand.
`timescale 1ns/1ps
module tb_ball_motion_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       done;
    logic [9:0] pad_l;
    logic [9:0] pad_r;
    logic       delay;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       score_l;
    logic       score_r;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ball_motion_controller dut (
        .CLK_100MHz  (clk),
        .Reset       (rst_n),
        .enable      (enable),
        .done        (done),
        .paddleLeftY (pad_l),
        .paddleRightY(pad_r),
        .delay       (delay),
        .ballX       (ball_x),
        .ballY       (ball_y),
        .scoreLeft   (score_l),
        .scoreRight  (score_r)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        else
            n_pass++;
    endtask

    // Called at a negedge while in SWAIT; returns at the negedge
    // right after the position update.
    task automatic tick();
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        done   = 1'b0;
        pad_l  = 10'd400;
        pad_r  = 10'd400;
        repeat (3) @(negedge clk);
        chk("rst_x", ball_x, 316);
        chk("rst_y", ball_y, 236);
        chk("rst_delay", delay, 0);
        chk("rst_sl", score_l, 0);
        chk("rst_sr", score_r, 0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("start_delay", delay, 1);

        tick();
        chk("free_x", ball_x, 318);
        chk("free_y", ball_y, 238);
        chk("free_delay", delay, 1);

        repeat (117) tick();
        chk("wall_y", ball_y, 472);
        tick();
        chk("wall_back_y", ball_y, 470);

        repeat (27) tick();
        chk("hit_x", ball_x, 608);
        chk("hit_y", ball_y, 416);
        tick();
        chk("hit_back_x", ball_x, 606);

        rst_n = 1'b0;
        #1;
        chk("rst2_x", ball_x, 316);
        @(negedge clk);
        rst_n = 1'b1;
        pad_r = 10'd0;
        @(negedge clk);
        repeat (157) tick();
        chk("pre_goal_x", ball_x, 630);
        chk("pre_goal_sl", score_l, 0);
        tick();
        chk("goal_sl", score_l, 1);
        chk("goal_sr", score_r, 0);
        chk("goal_x", ball_x, 316);
        chk("goal_y", ball_y, 236);
        @(negedge clk);
        chk("goal_sl_width", score_l, 0);
        tick();
        chk("serve_x", ball_x, 318);
        chk("serve_y", ball_y, 234);

        enable = 1'b0;
        @(negedge clk);
        chk("pause_delay", delay, 0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (3) @(negedge clk);
        chk("pause_x", ball_x, 318);
        chk("pause_y", ball_y, 234);
        enable = 1'b1;
        @(negedge clk);
        chk("resume_delay", delay, 1);
        tick();
        chk("resume_x", ball_x, 320);
        chk("resume_y", ball_y, 232);

        enable = 1'b0;
        done   = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("prio_delay", delay, 0);
        @(negedge clk);
        chk("prio_x", ball_x, 320);
        enable = 1'b1;
        @(negedge clk);

        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("upd_delay", delay, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_x", ball_x, 316);
        chk("midrst_y", ball_y, 236);
        chk("midrst_delay", delay, 0);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_sl", score_l, 0);
        chk("midrst_sr", score_r, 0);
        chk("midrst_hold_x", ball_x, 316);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
